// File: rtl/demux_1x4_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer with packet-locked select.
// Optional per-channel packet counters are enabled by defining DEMUX_1X4_STATS_EN.
module demux_1x4_stream #(
   parameter int DATA_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          s,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                in_valid,
   input  logic                in_last,
   output logic                in_ready,
   output logic [4*DATA_W-1:0] out_data,
   output logic [3:0]          out_valid,
   output logic [3:0]          out_last,
   input  logic [3:0]          out_ready,
   output logic                busy,
   output logic [63:0]         pkt_cnt
);

   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic [1:0] r_lock_sel;
   logic [1:0] w_lock_sel_next;
   logic [1:0] w_target;
   logic       w_accept;

   // Target is resolved outside the FSM block so acceptance never loops back through it.
   assign w_target = (r_state == LOCK) ? r_lock_sel : s;
   assign in_ready = !out_valid[w_target] || out_ready[w_target];
   assign w_accept = in_valid && in_ready;
   assign busy     = (r_state == LOCK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_lock_sel <= 2'd0;
      end else begin
         r_state    <= w_state_next;
         r_lock_sel <= w_lock_sel_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_lock_sel_next = r_lock_sel;
      case (r_state)
         IDLE: begin
            if (w_accept && !in_last) begin
               w_state_next    = LOCK;
               w_lock_sel_next = s;
            end
         end
         LOCK: begin
            if (w_accept && in_last) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_ch
         logic              r_valid;
         logic              r_last;
         logic [DATA_W-1:0] r_data;
         logic              w_hit;

         assign w_hit = w_accept && (w_target == 2'(gi));

         // A refill wins over a drain so a full channel can stream at one beat per cycle.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_valid <= 1'b0;
               r_last  <= 1'b0;
               r_data  <= '0;
            end else if (w_hit) begin
               r_valid <= 1'b1;
               r_last  <= in_last;
               r_data  <= in_data;
            end else if (r_valid && out_ready[gi]) begin
               r_valid <= 1'b0;
            end
         end

         assign out_valid[gi]                   = r_valid;
         assign out_last[gi]                    = r_last;
         assign out_data[gi*DATA_W +: DATA_W]   = r_data;

`ifdef DEMUX_1X4_STATS_EN
         logic [15:0] r_cnt;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cnt <= 16'd0;
            end else if (w_hit && in_last) begin
               r_cnt <= r_cnt + 16'd1;
            end
         end

         assign pkt_cnt[gi*16 +: 16] = r_cnt;
`else
         assign pkt_cnt[gi*16 +: 16] = 16'd0;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Self-checking bench for demux_1x4_stream: per-scenario tasks plus a scoreboard
// that matches every downstream handshake against the beats that were sent.
module tb_demux_1x4_stream;
   localparam int DW = 8;

`ifdef DEMUX_1X4_STATS_EN
   localparam logic [63:0] EXP_CNT_1 = 64'h0000_0000_0001_0000;
   localparam logic [63:0] EXP_CNT_F = 64'h0001_0000_0003_0000;
`else
   localparam logic [63:0] EXP_CNT_1 = 64'h0;
   localparam logic [63:0] EXP_CNT_F = 64'h0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      s;
   logic [DW-1:0]   in_data;
   logic            in_valid;
   logic            in_last;
   logic            in_ready;
   logic [4*DW-1:0] out_data;
   logic [3:0]      out_valid;
   logic [3:0]      out_last;
   logic [3:0]      out_ready;
   logic            busy;
   logic [63:0]     pkt_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int            ch;
      logic [DW-1:0] data;
      logic          last;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   demux_1x4_stream #(.DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .s(s), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_last(out_last), .out_ready(out_ready), .busy(busy), .pkt_cnt(pkt_cnt)
   );

   // Downstream monitor: a beat valid and ready at the falling edge is consumed at the next rising edge.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         for (int k = 0; k < 4; k++) begin
            if (out_valid[k] && out_ready[k]) begin
               int idx;
               idx = -1;
               for (int i = 0; i < sb.size(); i++)
                  if (idx < 0 && sb[i].ch == k) idx = i;
               n_cmp++;
               if (idx < 0) begin
                  n_bad++;
                  $display("FAIL sb_unexpected ch%0d: got data=%h last=%b, expected no beat",
                           k, out_data[k*DW +: DW], out_last[k]);
               end else begin
                  if (out_data[k*DW +: DW] !== sb[idx].data || out_last[k] !== sb[idx].last) begin
                     n_bad++;
                     $display("FAIL sb_beat ch%0d: got data=%h last=%b, expected data=%h last=%b",
                              k, out_data[k*DW +: DW], out_last[k], sb[idx].data, sb[idx].last);
                  end else begin
                     $display("beat ch%0d data=%h last=%b", k, sb[idx].data, sb[idx].last);
                  end
                  sb.delete(idx);
               end
            end
         end
      end
   end

   task automatic drive_beat(input logic [1:0] sel, input logic [DW-1:0] d,
                             input logic l, input int ch);
      exp_t e;
      bit   done;
      s = sel; in_data = d; in_last = l; in_valid = 1'b1;
      e.ch = ch; e.data = d; e.last = l;
      sb.push_back(e);
      done = 1'b0;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         if (in_ready === 1'b1) done = 1'b1;
         @(posedge clk); #1;
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout: beat %h never accepted, expected acceptance", d);
      end
   endtask

   task automatic idle();
      in_valid = 1'b0; in_last = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; s = 2'd0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 4'hF;
      #2;
      n_cmp++; if (out_valid !== 4'b0000 || out_last !== 4'b0000) begin n_bad++;
         $display("FAIL reset_valid_last: got %b/%b, expected 0000/0000", out_valid, out_last); end
      n_cmp++; if (out_data !== '0) begin n_bad++;
         $display("FAIL reset_data: got %h, expected 0", out_data); end
      n_cmp++; if (busy !== 1'b0 || pkt_cnt !== 64'h0) begin n_bad++;
         $display("FAIL reset_busy_cnt: got %b/%h, expected 0/0", busy, pkt_cnt); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++;
         $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      drive_beat(2'd2, 8'hA5, 1'b1, 2);
      n_cmp++; if (out_valid !== 4'b0100) begin n_bad++;
         $display("FAIL single_valid: got %b, expected 0100", out_valid); end
      n_cmp++; if (out_data[23:16] !== 8'hA5 || out_last[2] !== 1'b1) begin n_bad++;
         $display("FAIL single_data: got %h last=%b, expected a5 last=1", out_data[23:16], out_last[2]); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++;
         $display("FAIL single_busy: got %b, expected 0", busy); end
      idle();
      n_cmp++; if (out_valid !== 4'b0000) begin n_bad++;
         $display("FAIL single_drain: got %b, expected 0000", out_valid); end
   endtask

   task automatic test_lock();
      drive_beat(2'd1, 8'h11, 1'b0, 1);
      n_cmp++; if (busy !== 1'b1 || out_valid !== 4'b0010) begin n_bad++;
         $display("FAIL lock_b1: got busy=%b valid=%b, expected 1/0010", busy, out_valid); end
      n_cmp++; if (out_data[15:8] !== 8'h11 || out_last[1] !== 1'b0) begin n_bad++;
         $display("FAIL lock_b1_data: got %h/%b, expected 11/0", out_data[15:8], out_last[1]); end
      drive_beat(2'd3, 8'h22, 1'b0, 1);
      n_cmp++; if (busy !== 1'b1 || out_valid !== 4'b0010 || out_data[15:8] !== 8'h22) begin n_bad++;
         $display("FAIL lock_b2: got busy=%b valid=%b data=%h, expected 1/0010/22", busy, out_valid, out_data[15:8]); end
      drive_beat(2'd3, 8'h33, 1'b1, 1);
      n_cmp++; if (busy !== 1'b0 || out_valid !== 4'b0010) begin n_bad++;
         $display("FAIL lock_b3: got busy=%b valid=%b, expected 0/0010", busy, out_valid); end
      n_cmp++; if (out_data[15:8] !== 8'h33 || out_last[1] !== 1'b1) begin n_bad++;
         $display("FAIL lock_b3_data: got %h/%b, expected 33/1", out_data[15:8], out_last[1]); end
      idle();
   endtask

   task automatic test_stall();
      exp_t e;
      out_ready = 4'b1110;
      drive_beat(2'd0, 8'h44, 1'b1, 0);
      n_cmp++; if (out_valid[0] !== 1'b1) begin n_bad++;
         $display("FAIL stall_first: got %b, expected 1", out_valid[0]); end
      s = 2'd0; in_data = 8'h55; in_last = 1'b1; in_valid = 1'b1;
      e.ch = 0; e.data = 8'h55; e.last = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++;
         $display("FAIL stall_ready_low: got %b, expected 0", in_ready); end
      @(posedge clk); #1;
      n_cmp++; if (out_data[7:0] !== 8'h44 || out_valid[0] !== 1'b1) begin n_bad++;
         $display("FAIL stall_hold: got %h/%b, expected 44/1", out_data[7:0], out_valid[0]); end
      out_ready = 4'hF;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++;
         $display("FAIL stall_ready_same_cycle: got %b, expected 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++; if (out_data[7:0] !== 8'h55 || out_valid[0] !== 1'b1) begin n_bad++;
         $display("FAIL stall_second: got %h/%b, expected 55/1", out_data[7:0], out_valid[0]); end
      idle();
      n_cmp++; if (out_valid !== 4'b0000) begin n_bad++;
         $display("FAIL stall_drain: got %b, expected 0000", out_valid); end
   endtask

   task automatic test_independent();
      out_ready = 4'b1110;
      drive_beat(2'd0, 8'h66, 1'b1, 0);
      drive_beat(2'd3, 8'h77, 1'b1, 3);
      n_cmp++; if (out_valid !== 4'b1001) begin n_bad++;
         $display("FAIL indep_valid: got %b, expected 1001", out_valid); end
      n_cmp++; if (out_data[7:0] !== 8'h66 || out_data[31:24] !== 8'h77) begin n_bad++;
         $display("FAIL indep_data: got ch0=%h ch3=%h, expected 66/77", out_data[7:0], out_data[31:24]); end
      idle();
      n_cmp++; if (out_valid !== 4'b0001) begin n_bad++;
         $display("FAIL indep_ch3_drain: got %b, expected 0001", out_valid); end
      out_ready = 4'hF;
      idle();
      n_cmp++; if (out_valid !== 4'b0000) begin n_bad++;
         $display("FAIL indep_all_drain: got %b, expected 0000", out_valid); end
   endtask

   task automatic test_reset_mid();
      out_ready = 4'b1011;
      drive_beat(2'd2, 8'h81, 1'b0, 2);
      n_cmp++; if (busy !== 1'b1 || out_valid !== 4'b0100) begin n_bad++;
         $display("FAIL rstmid_pre: got busy=%b valid=%b, expected 1/0100", busy, out_valid); end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0 || out_valid !== 4'b0000 || out_data !== '0) begin n_bad++;
         $display("FAIL rstmid_async: got busy=%b valid=%b data=%h, expected 0/0000/0", busy, out_valid, out_data); end
      sb.delete();
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1; out_ready = 4'hF;
      drive_beat(2'd0, 8'h90, 1'b1, 0);
      n_cmp++; if (out_valid !== 4'b0001 || out_data[7:0] !== 8'h90 || busy !== 1'b0) begin n_bad++;
         $display("FAIL rstmid_after: got valid=%b data=%h busy=%b, expected 0001/90/0", out_valid, out_data[7:0], busy); end
      idle();
   endtask

   task automatic test_stats();
      rst_n = 1'b0;
      #1;
      n_cmp++; if (pkt_cnt !== 64'h0) begin n_bad++;
         $display("FAIL stats_clear: got %h, expected 0", pkt_cnt); end
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive_beat(2'd1, 8'h01, 1'b0, 1);
      drive_beat(2'd2, 8'h02, 1'b1, 1);
      n_cmp++; if (pkt_cnt !== EXP_CNT_1) begin n_bad++;
         $display("FAIL stats_first: got %h, expected %h", pkt_cnt, EXP_CNT_1); end
      drive_beat(2'd1, 8'h03, 1'b1, 1);
      drive_beat(2'd1, 8'h04, 1'b1, 1);
      drive_beat(2'd3, 8'h05, 1'b1, 3);
      idle();
      n_cmp++; if (pkt_cnt !== EXP_CNT_F) begin n_bad++;
         $display("FAIL stats_final: got %h, expected %h", pkt_cnt, EXP_CNT_F); end
      idle();
      n_cmp++; if (sb.size() != 0) begin n_bad++;
         $display("FAIL sb_leftover: got %0d pending beats, expected 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_lock();
      test_stall();
      test_independent();
      test_reset_mid();
      test_stats();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
